// File: rtl/fir_display_pkg.sv
// Shared types and helpers for the FIR result display path.
package fir_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int BCD_W = 16;

  // Active-high {g,f,e,d,c,b,a} pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // BCD nibble to active-high {g,f,e,d,c,b,a}; codes above 9 are dark.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fir_result_display_bin2bcd.sv
// Sequential double-dabble: 12-bit binary to 4 BCD digits, one shift per clock.
// Samples that arrive while a conversion runs are held in a 1-deep pending
// register; a newer sample silently replaces an older held one.
module bin2bcd_seq
  import fir_display_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [11:0]      i_data,
  input  logic             i_data_valid,
  output logic             o_busy,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_bcd_valid
);

  conv_state_t      state_q, state_d;
  logic [27:0]      sr_q, sr_d;
  logic [27:0]      adj;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_vld_q, pend_vld_d;
  logic [11:0]      pend_data_q, pend_data_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             bcd_valid_q, bcd_valid_d;

  // Next-state, shift register and pending-sample logic.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    adj         = sr_q;
    case (state_q)
      IDLE: begin
        // A fresh strobe takes priority over a held sample.
        if (i_data_valid) begin
          sr_d       = {16'b0, i_data};
          cnt_d      = 4'd0;
          pend_vld_d = 1'b0;
          state_d    = SHIFT;
        end else if (pend_vld_q) begin
          sr_d       = {16'b0, pend_data_q};
          cnt_d      = 4'd0;
          pend_vld_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        for (int i = 0; i < 4; i++) begin
          if (adj[12+4*i +: 4] >= 4'd5) adj[12+4*i +: 4] = adj[12+4*i +: 4] + 4'd3;
        end
        sr_d = {adj[26:0], 1'b0};
        if (cnt_q == 4'd11) state_d = DONE;
        else                cnt_d   = cnt_q + 4'd1;
      end
      DONE: begin
        bcd_d       = sr_q[27:12];
        bcd_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_data_valid && (state_q != IDLE)) begin
      pend_vld_d  = 1'b1;
      pend_data_d = i_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign o_busy      = (state_q != IDLE) | pend_vld_q;
  assign o_bcd       = bcd_q;
  assign o_bcd_valid = bcd_valid_q;

endmodule

// File: rtl/fir_result_display.sv
// FIR result display: BCD conversion plus a time-multiplexed 4-digit
// 7-segment driver showing the value as "dd.dd".
module fir_result_display
  import fir_display_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int SEG_ACT_LO = 1,
  parameter int DP_DIGIT   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  output logic              o_busy,
  output logic [BCD_W-1:0]  o_bcd,
  output logic              o_bcd_valid,
  output logic [7:0]        o_seg,
  output logic [DIGITS-1:0] o_an
);

  localparam int CNT_W = $clog2(SCAN_DIV + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_OFF = (SEG_ACT_LO != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (SEG_ACT_LO != 0) ? '1 : '0;

  logic [BCD_W-1:0]  bcd;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        nib;
  logic [6:0]        seg_hi;
  logic [7:0]        seg_act;
  logic [DIGITS-1:0] an_act;

  bin2bcd_seq u_conv (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_busy       (o_busy),
    .o_bcd        (bcd),
    .o_bcd_valid  (o_bcd_valid)
  );

  // Scan timing and the segment/anode pattern for the digit selected next.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    nib    = bcd[{idx_d, 2'b00} +: 4];
    seg_hi = seg7_decode(nib);
    // Suppress a leading zero on the most significant digit only.
    if ((idx_d == IDX_W'(DIGITS - 1)) && (nib == 4'd0)) seg_hi = SEG_BLANK;
    seg_act = {(idx_d == IDX_W'(DP_DIGIT)), seg_hi};
    an_act  = DIGITS'(1) << idx_d;
    seg_d   = (SEG_ACT_LO != 0) ? ~seg_act : seg_act;
    an_d    = (SEG_ACT_LO != 0) ? ~an_act  : an_act;
  end

  // Scan registers; anodes and segments move on the same edge as the index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign o_bcd = bcd;
  assign o_seg = seg_q;
  assign o_an  = an_q;

endmodule

// File: tb/tb_fir_result_display.sv
// Directed bench for fir_result_display with a short scan period.
module tb_fir_result_display;

  logic        clk;
  logic        rst_n;
  logic [11:0] data;
  logic        data_valid;
  logic        busy;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [7:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  fir_result_display #(.SCAN_DIV(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_data_valid (data_valid),
    .o_busy       (busy),
    .o_bcd        (bcd),
    .o_bcd_valid  (bcd_valid),
    .o_seg        (seg),
    .o_an         (an)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low {dp,g..a} constants for the digits the bench displays.
  localparam logic [7:0] S_BLANK = 8'hFF;
  localparam logic [7:0] S_0 = 8'hC0, S_0DP = 8'h40, S_1 = 8'hF9, S_5 = 8'h92;
  localparam logic [7:0] S_8 = 8'h80, S_9 = 8'h90, S_9DP = 8'h10;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (an === target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Strobe one sample and wait for its result pulse, then let the display catch up.
  task automatic convert(input logic [11:0] value, output bit ok, output logic [15:0] result);
    ok = 1'b0;
    result = 'x;
    data = value;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bcd_valid === 1'b1) begin
        ok = 1'b1;
        result = bcd;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data = '0;
    data_valid = 1'b0;
    repeat (5) tick();
    checks++; if (bcd !== 16'h0) begin errors++; $display("FAIL reset_bcd got %h exp 0000", bcd); end
    checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_bcd_valid got %b exp 0", bcd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp f", an); end
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h exp ff", seg); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_1008();
    logic [7:0] exp_seg[4];
    logic [3:0] an_t;
    bit ok;
    data = 12'd1008;
    data_valid = 1'b1;
    tick();                                   // edge k
    data_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept got %b exp 1", busy); end
    for (int j = 1; j <= 12; j++) begin
      tick();
      checks++;
      if (bcd_valid !== 1'b0 || bcd !== 16'h0) begin
        errors++; $display("FAIL early_result at k+%0d got valid %b bcd %h exp 0 0000", j, bcd_valid, bcd);
      end
    end
    tick();                                   // edge k+13
    checks++; if (bcd_valid !== 1'b1) begin errors++; $display("FAIL latency_pulse got %b exp 1", bcd_valid); end
    checks++; if (bcd !== 16'h1008) begin errors++; $display("FAIL bcd_1008 got %h exp 1008", bcd); end
    tick();
    checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL pulse_width got %b exp 0", bcd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_release got %b exp 0", busy); end
    exp_seg = '{S_8, S_0, S_0DP, S_1};
    for (int d = 0; d < 4; d++) begin
      an_t = ~(4'b0001 << d);
      wait_an(an_t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL disp1008_an%0d got %h exp %h", d, an, an_t); end
      else if (seg !== exp_seg[d]) begin errors++; $display("FAIL disp1008_seg%0d got %h exp %h", d, seg, exp_seg[d]); end
    end
  endtask

  task automatic test_small();
    logic [7:0] exp_seg[4];
    logic [15:0] res;
    logic [3:0] an_t;
    bit ok;
    convert(12'd50, ok, res);
    checks++; if (!ok || res !== 16'h0050) begin errors++; $display("FAIL bcd_50 got %h exp 0050", res); end
    exp_seg = '{S_0, S_5, S_0DP, S_BLANK};
    for (int d = 0; d < 4; d++) begin
      an_t = ~(4'b0001 << d);
      wait_an(an_t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL disp50_an%0d got %h exp %h", d, an, an_t); end
      else if (seg !== exp_seg[d]) begin errors++; $display("FAIL disp50_seg%0d got %h exp %h", d, seg, exp_seg[d]); end
    end
    convert(12'd0, ok, res);
    checks++; if (!ok || res !== 16'h0000) begin errors++; $display("FAIL bcd_0 got %h exp 0000", res); end
    exp_seg = '{S_0, S_0, S_0DP, S_BLANK};
    for (int d = 0; d < 4; d++) begin
      an_t = ~(4'b0001 << d);
      wait_an(an_t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL disp0_an%0d got %h exp %h", d, an, an_t); end
      else if (seg !== exp_seg[d]) begin errors++; $display("FAIL disp0_seg%0d got %h exp %h", d, seg, exp_seg[d]); end
    end
    convert(12'd4095, ok, res);
    checks++; if (!ok || res !== 16'h4095) begin errors++; $display("FAIL bcd_4095 got %h exp 4095", res); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    int exp_cyc[$];
    int pulses;
    logic [15:0] e;
    int ec;
    exp_q = '{16'h0100, 16'h0007};
    exp_cyc = '{13, 27};
    pulses = 0;
    data = 12'd100;
    data_valid = 1'b1;
    tick();                                   // edge k
    data_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      data_valid = (cyc == 3) || (cyc == 5);
      data = (cyc == 3) ? 12'd4095 : (cyc == 5) ? 12'd7 : 12'd0;
      tick();
      data_valid = 1'b0;
      if (cyc == 14) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pending_busy got %b exp 1", busy); end
      end
      if (bcd_valid === 1'b1) begin
        pulses++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_pulse got %h at k+%0d exp none", bcd, cyc);
        end else begin
          e = exp_q.pop_front();
          ec = exp_cyc.pop_front();
          if (bcd !== e || cyc != ec) begin
            errors++; $display("FAIL b2b_result got %h at k+%0d exp %h at k+%0d", bcd, cyc, e, ec);
          end
        end
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_scan();
    logic [3:0] seq[5];
    logic [3:0] cur;
    int n;
    bit ok;
    seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    wait_an(4'hE, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan_start got %h exp e", an); end
    for (int s = 0; s < 4; s++) begin
      cur = an;
      checks++;
      if (seg[7] !== ((cur == 4'hB) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL scan_dp on an %h got %b exp %b", cur, seg[7], (cur == 4'hB) ? 1'b0 : 1'b1);
      end
      n = 1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (an !== cur) break;
        n++;
      end
      checks++;
      if (n != 4 || an !== seq[s+1]) begin
        errors++; $display("FAIL scan_step%0d got dwell %0d next %h exp dwell 4 next %h", s, n, an, seq[s+1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_seg[4];
    logic [15:0] res;
    logic [3:0] an_t;
    bit ok;
    int pulses;
    data = 12'd999;
    data_valid = 1'b1;
    tick();                                   // edge k
    data_valid = 1'b0;
    repeat (5) tick();                        // edges k+1..k+5
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", busy); end
    checks++; if (bcd !== 16'h0) begin errors++; $display("FAIL async_bcd got %h exp 0000", bcd); end
    checks++; if (an !== 4'hF || seg !== 8'hFF) begin errors++; $display("FAIL async_disp got %h %h exp f ff", an, seg); end
    repeat (3) tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bcd_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0 || bcd !== 16'h0) begin errors++; $display("FAIL aborted got pulses %0d bcd %h exp 0 0000", pulses, bcd); end
    convert(12'd999, ok, res);
    checks++; if (!ok || res !== 16'h0999) begin errors++; $display("FAIL bcd_999 got %h exp 0999", res); end
    exp_seg = '{S_9, S_9, S_9DP, S_BLANK};
    for (int d = 0; d < 4; d++) begin
      an_t = ~(4'b0001 << d);
      wait_an(an_t, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL disp999_an%0d got %h exp %h", d, an, an_t); end
      else if (seg !== exp_seg[d]) begin errors++; $display("FAIL disp999_seg%0d got %h exp %h", d, seg, exp_seg[d]); end
    end
  endtask

  // Scenario sequence and final report
  initial begin
    rst_n = 1'b1;
    data = '0;
    data_valid = 1'b0;
    #1;
    test_reset();
    test_1008();
    test_small();
    test_back_to_back();
    test_scan();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
